// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator sequencer: opcode classes, acc_ctl codes and FSM states.
package acc_pkg;

  localparam logic [2:0] CLS_ALU  = 3'b000;
  localparam logic [2:0] CLS_MEM  = 3'b001;
  localparam logic [2:0] CLS_IMM  = 3'b010;
  localparam logic [2:0] CLS_HALT = 3'b011;
  localparam logic [2:0] CLS_EQ   = 3'b100;
  localparam logic [2:0] CLS_MOV  = 3'b101;
  localparam logic [2:0] CLS_JR   = 3'b110;
  localparam logic [2:0] CLS_JMP  = 3'b111;

  localparam logic [2:0] ACC_HOLD   = 3'b000;
  localparam logic [2:0] ACC_UNARY  = 3'b001;
  localparam logic [2:0] ACC_BINOP  = 3'b010;
  localparam logic [2:0] ACC_LOAD   = 3'b011;
  localparam logic [2:0] ACC_TO_REG = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

endpackage

// File: rtl/acc_op_class.sv
// Combinational opcode classifier: IR -> accumulator control and control-flow attributes.
module acc_op_class
  import acc_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  logic [OP_W-1:0] i_ir,
  input  logic            i_eq_flag,
  output logic [2:0]      o_acc_ctl,
  output logic            o_is_mem,
  output logic            o_is_jump,
  output logic            o_is_halt,
  output logic            o_illegal,
  output logic            o_acc_wr,
  output logic            o_rf_wr
);

  logic [2:0] w_cls;
  logic [2:0] w_func;

  assign w_cls  = i_ir[OP_W-1 -: 3];
  assign w_func = i_ir[2:0];

  always_comb begin
    o_acc_ctl = ACC_HOLD;
    o_is_mem  = 1'b0;
    o_is_jump = 1'b0;
    o_is_halt = 1'b0;
    o_illegal = 1'b0;
    o_acc_wr  = 1'b0;
    o_rf_wr   = 1'b0;
    case (w_cls)
      CLS_ALU: begin
        if (w_func <= 3'b011) begin
          o_acc_ctl = ACC_BINOP;
          o_acc_wr  = 1'b1;
        end else if (w_func == 3'b101 || w_func == 3'b110) begin
          o_acc_ctl = ACC_UNARY;
          o_acc_wr  = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      CLS_MEM: begin
        o_is_mem = 1'b1;
        // IR[0] selects store; only loads touch the accumulator
        if (!i_ir[0]) begin
          o_acc_ctl = ACC_LOAD;
          o_acc_wr  = 1'b1;
        end
      end
      CLS_IMM: begin
        o_acc_ctl = ACC_BINOP;
        o_acc_wr  = 1'b1;
      end
      CLS_HALT: o_is_halt = 1'b1;
      CLS_EQ:   o_is_jump = i_eq_flag;
      CLS_MOV: begin
        o_acc_ctl = ACC_TO_REG;
        o_rf_wr   = 1'b1;
      end
      CLS_JR, CLS_JMP: o_is_jump = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the accumulator datapath.
// Define ACC_SEQ_PERF_EN to add the saturating cycle and instruction counters.
module acc_seq_ctrl
  import acc_pkg::*;
#(
  parameter int unsigned OP_W        = 6,
  parameter int unsigned TMO_W       = 4,
  parameter int unsigned MEM_TIMEOUT = 12
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [OP_W-1:0] i_imem_op,
  input  logic            i_eq_flag,
  input  logic            i_dmem_ack,
  output logic            o_pc_en,
  output logic            o_pc_jump,
  output logic            o_ir_load,
  output logic [2:0]      o_acc_ctl,
  output logic            o_acc_we,
  output logic            o_rf_we,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic            o_busy,
  output logic            o_halted,
  output logic            o_fault
`ifdef ACC_SEQ_PERF_EN
  ,
  output logic [31:0]     o_cyc_cnt,
  output logic [31:0]     o_instr_cnt
`endif
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e            r_state, w_state_d;
  logic [OP_W-1:0]   r_ir, w_ir_d;
  logic [TMO_W-1:0]  r_tmo, w_tmo_d;
  logic              r_fault, w_fault_d;
  logic              r_take, w_take_d;

  logic [2:0]        w_acc_ctl;
  logic              w_is_mem;
  logic              w_is_jump;
  logic              w_is_halt;
  logic              w_illegal;
  logic              w_acc_wr;
  logic              w_rf_wr;

  acc_op_class #(
    .OP_W(OP_W)
  ) u_op_class (
    .i_ir      (r_ir),
    .i_eq_flag (i_eq_flag),
    .o_acc_ctl (w_acc_ctl),
    .o_is_mem  (w_is_mem),
    .o_is_jump (w_is_jump),
    .o_is_halt (w_is_halt),
    .o_illegal (w_illegal),
    .o_acc_wr  (w_acc_wr),
    .o_rf_wr   (w_rf_wr)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_ir    <= '0;
      r_tmo   <= '0;
      r_fault <= 1'b0;
      r_take  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ir    <= w_ir_d;
      r_tmo   <= w_tmo_d;
      r_fault <= w_fault_d;
      r_take  <= w_take_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_ir_d    = r_ir;
    w_tmo_d   = r_tmo;
    w_fault_d = r_fault;
    w_take_d  = r_take;
    case (r_state)
      StIdle:   if (i_start) w_state_d = StFetch;
      StFetch:  w_state_d = StDecode;
      StDecode: begin
        w_ir_d    = i_imem_op;
        w_state_d = StExec;
      end
      StExec: begin
        // EQ outcome is frozen here so WB sees a stable jump decision
        w_take_d = w_is_jump;
        if (w_illegal) begin
          w_state_d = StHalt;
          w_fault_d = 1'b1;
        end else if (w_is_halt) begin
          w_state_d = StHalt;
        end else if (w_is_mem) begin
          w_state_d = StMem;
          w_tmo_d   = '0;
        end else begin
          w_state_d = StWb;
        end
      end
      StMem: begin
        if (i_dmem_ack) begin
          w_state_d = StWb;
        end else if (r_tmo == TMO_LAST) begin
          w_state_d = StHalt;
          w_fault_d = 1'b1;
        end else begin
          w_tmo_d = r_tmo + TMO_W'(1);
        end
      end
      StWb:    w_state_d = StFetch;
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIdle;
    endcase
  end

  // Moore outputs from registered state, so reset clears them without waiting for a clock
  always_comb begin
    o_pc_en    = 1'b0;
    o_pc_jump  = 1'b0;
    o_ir_load  = 1'b0;
    o_acc_ctl  = ACC_HOLD;
    o_acc_we   = 1'b0;
    o_rf_we    = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_busy     = (r_state != StIdle) && (r_state != StHalt);
    o_halted   = (r_state == StHalt);
    o_fault    = r_fault;
    case (r_state)
      StDecode: o_ir_load = 1'b1;
      StExec:   if (!w_is_mem) o_acc_ctl = w_acc_ctl;
      StMem: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = r_ir[0];
        o_acc_ctl  = w_acc_ctl;
      end
      StWb: begin
        o_acc_ctl = w_acc_ctl;
        o_acc_we  = w_acc_wr;
        o_rf_we   = w_rf_wr;
        o_pc_jump = r_take;
        o_pc_en   = !r_take;
      end
      default: ;
    endcase
  end

`ifdef ACC_SEQ_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cyc_cnt   <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (o_busy && (r_cyc_cnt != '1)) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if ((r_state == StWb) && (r_instr_cnt != '1)) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign o_cyc_cnt   = r_cyc_cnt;
  assign o_instr_cnt = r_instr_cnt;
`endif

endmodule
